// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with frame-synchronous double buffering and blink.
// Outputs are registered one cycle behind the scan index; loads take effect only at frame wrap.
module seven_seg_scan_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digit_codes,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   output logic [0:6]              segments,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   anode_active,
   output logic                    frame_done
);

   localparam int IDX_W  = $clog2(NUM_DIGITS);
   localparam int CNT_W  = $clog2(REFRESH_DIV);
   localparam int BLK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int CODE_W = 4 * NUM_DIGITS;

   logic [CNT_W-1:0]      r_refresh_cnt;
   logic [IDX_W-1:0]      r_scan_idx;
   logic [BLK_W-1:0]      r_blink_cnt;
   logic                  r_blink_phase;
   logic                  r_pending;
   logic [CODE_W-1:0]     r_stg_codes;
   logic [NUM_DIGITS-1:0] r_stg_dp;
   logic [NUM_DIGITS-1:0] r_stg_en;
   logic [NUM_DIGITS-1:0] r_stg_blink;
   logic [CODE_W-1:0]     r_act_codes;
   logic [NUM_DIGITS-1:0] r_act_dp;
   logic [NUM_DIGITS-1:0] r_act_en;
   logic [NUM_DIGITS-1:0] r_act_blink;
   logic [0:6]            r_segments;
   logic                  r_dp;
   logic [NUM_DIGITS-1:0] r_anode;
   logic                  r_frame_done;

   logic                  w_slot_end;
   logic                  w_frame_wrap;
   logic [IDX_W-1:0]      w_anode_k;
   logic [3:0]            w_code;
   logic                  w_blank;
   logic [0:6]            w_seg;
   logic [NUM_DIGITS-1:0] w_anode_sel;

   assign w_slot_end   = (r_refresh_cnt == CNT_W'(REFRESH_DIV - 1));
   assign w_frame_wrap = w_slot_end && (r_scan_idx == IDX_W'(NUM_DIGITS - 1));
   // Scan starts at the leftmost (MSB) anode.
   assign w_anode_k    = IDX_W'(NUM_DIGITS - 1) - r_scan_idx;
   assign w_code       = r_act_codes[{w_anode_k, 2'b00} +: 4];
   assign w_blank      = ~r_act_en[w_anode_k] | (r_act_blink[w_anode_k] & r_blink_phase);
   assign w_anode_sel  = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << w_anode_k;

   always_comb begin
      w_seg = 7'b1111111;
      case (w_code)
         4'd0:    w_seg = 7'b0000001;
         4'd1:    w_seg = 7'b1001111;
         4'd2:    w_seg = 7'b0010010;
         4'd3:    w_seg = 7'b0000110;
         4'd4:    w_seg = 7'b1001100;
         4'd5:    w_seg = 7'b0100100;
         4'd6:    w_seg = 7'b0100000;
         4'd7:    w_seg = 7'b0001111;
         4'd8:    w_seg = 7'b0000000;
         4'd9:    w_seg = 7'b0000100;
         4'd10:   w_seg = 7'b1111110;
         4'd11:   w_seg = 7'b0111001;
         4'd14:   w_seg = 7'b0110000;
         default: w_seg = 7'b1111111;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_refresh_cnt <= '0;
         r_scan_idx    <= '0;
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b0;
      end else begin
         if (w_slot_end) begin
            r_refresh_cnt <= '0;
            r_scan_idx    <= w_frame_wrap ? '0 : r_scan_idx + IDX_W'(1);
         end else begin
            r_refresh_cnt <= r_refresh_cnt + CNT_W'(1);
         end
         if (w_frame_wrap) begin
            if (r_blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
               r_blink_cnt   <= '0;
               r_blink_phase <= ~r_blink_phase;
            end else begin
               r_blink_cnt <= r_blink_cnt + BLK_W'(1);
            end
         end
      end
   end

   // A load landing on the wrap cycle bypasses staging so it shows in the very next slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pending   <= 1'b0;
         r_stg_codes <= '0;
         r_stg_dp    <= '0;
         r_stg_en    <= '0;
         r_stg_blink <= '0;
         r_act_codes <= '0;
         r_act_dp    <= '0;
         r_act_en    <= '0;
         r_act_blink <= '0;
      end else begin
         if (load) begin
            r_stg_codes <= digit_codes;
            r_stg_dp    <= dp_in;
            r_stg_en    <= digit_en;
            r_stg_blink <= blink_mask;
         end
         if (w_frame_wrap) begin
            r_pending <= 1'b0;
            if (load) begin
               r_act_codes <= digit_codes;
               r_act_dp    <= dp_in;
               r_act_en    <= digit_en;
               r_act_blink <= blink_mask;
            end else if (r_pending) begin
               r_act_codes <= r_stg_codes;
               r_act_dp    <= r_stg_dp;
               r_act_en    <= r_stg_en;
               r_act_blink <= r_stg_blink;
            end
         end else if (load) begin
            r_pending <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_segments   <= 7'b1111111;
         r_dp         <= 1'b1;
         r_anode      <= '1;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_frame_wrap;
         if (w_blank) begin
            r_segments <= 7'b1111111;
            r_dp       <= 1'b1;
            r_anode    <= '1;
         end else begin
            r_segments <= w_seg;
            r_dp       <= ~r_act_dp[w_anode_k];
            r_anode    <= ~w_anode_sel;
         end
      end
   end

   assign segments     = r_segments;
   assign dp           = r_dp;
   assign anode_active = r_anode;
   assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver: stimulus queues one expected frame per scan,
// the monitor compares the 16 captured cycles when frame_done pulses.
module tb_seven_seg_scan_driver;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [15:0] digit_codes = '0;
   logic [3:0]  dp_in = '0;
   logic [3:0]  digit_en = '0;
   logic [3:0]  blink_mask = '0;
   logic [0:6]  segments;
   logic        dp;
   logic [3:0]  anode_active;
   logic        frame_done;

   int checks = 0;
   int errors = 0;

   typedef logic [11:0] slot_t;   // {anode, segments, dp}
   typedef logic [47:0] frame_t;  // slot i at [12*i +: 12]
   frame_t exp_q[$];

   logic [15:0] d_codes [6];
   logic [3:0]  d_en    [6];
   logic [3:0]  d_dp    [6];
   logic [3:0]  d_blink [6];

   int fr_show [10];
   int fr_k1   [10];
   int fr_d1   [10];
   int fr_k2   [10];
   int fr_d2   [10];

   seven_seg_scan_driver #(
      .NUM_DIGITS   (4),
      .REFRESH_DIV  (4),
      .BLINK_FRAMES (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .load         (load),
      .digit_codes  (digit_codes),
      .dp_in        (dp_in),
      .digit_en     (digit_en),
      .blink_mask   (blink_mask),
      .segments     (segments),
      .dp           (dp),
      .anode_active (anode_active),
      .frame_done   (frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [0:6] dec(input logic [3:0] c);
      case (c)
         4'd0:    return 7'b0000001;
         4'd1:    return 7'b1001111;
         4'd2:    return 7'b0010010;
         4'd3:    return 7'b0000110;
         4'd4:    return 7'b1001100;
         4'd5:    return 7'b0100100;
         4'd6:    return 7'b0100000;
         4'd7:    return 7'b0001111;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0000100;
         4'd10:   return 7'b1111110;
         4'd11:   return 7'b0111001;
         4'd14:   return 7'b0110000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic frame_t exp_frame(input int d, input logic ph);
      frame_t f;
      f = '0;
      for (int i = 0; i < 4; i++) begin
         int k;
         logic [3:0] an;
         logic [0:6] sg;
         logic p;
         k = 3 - i;
         if (!d_en[d][k] || (d_blink[d][k] && ph)) begin
            an = 4'hf;
            sg = 7'b1111111;
            p  = 1'b1;
         end else begin
            an    = 4'hf;
            an[k] = 1'b0;
            sg    = dec(d_codes[d][4*k +: 4]);
            p     = ~d_dp[d][k];
         end
         f[12*i +: 12] = {an, sg, p};
      end
      return f;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
      end
   endtask

   task automatic cyc(input int d);
      if (d >= 0) begin
         load        = 1'b1;
         digit_codes = d_codes[d];
         dp_in       = d_dp[d];
         digit_en    = d_en[d];
         blink_mask  = d_blink[d];
      end else begin
         load = 1'b0;
      end
      @(negedge clk);
   endtask

   // Monitor: capture every cycle after the edge, compare a whole frame on frame_done.
   slot_t mbuf [16];
   int    mcnt = 0;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            mcnt = 0;
            continue;
         end
         if (mcnt < 16) mbuf[mcnt] = {anode_active, segments, dp};
         mcnt++;
         checks++;
         if (anode_active != 4'hf && $countones(~anode_active) != 1) begin
            errors++;
            $display("FAIL anode_legal actual=%b required=one-low-or-all-high", anode_active);
         end
         if (frame_done) begin
            checks++;
            if (mcnt != 16) begin
               errors++;
               $display("FAIL frame_period actual=%0d expected=16", mcnt);
            end
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL frame_unexpected actual=frame_done expected=no_frame");
            end else begin
               frame_t e;
               e = exp_q.pop_front();
               for (int s = 0; s < 4; s++) begin
                  logic ok;
                  slot_t bad;
                  ok  = 1'b1;
                  bad = '0;
                  for (int c = 0; c < 4; c++) begin
                     if (mbuf[4*s+c] !== e[12*s +: 12]) begin
                        ok  = 1'b0;
                        bad = mbuf[4*s+c];
                     end
                  end
                  checks++;
                  if (!ok) begin
                     errors++;
                     $display("FAIL slot%0d {an,seg,dp} actual=%b expected=%b", s, bad, e[12*s +: 12]);
                  end
               end
            end
            mcnt = 0;
         end
      end
   end

   initial begin
      // Data sets: 0 reset/blank, 1 "3210", 2 "Err-", 3 "9876" blink anode3,
      // 4 enable 0101 with blank codes, 5 "8888"
      d_codes[0] = 16'h0000; d_en[0] = 4'b0000; d_dp[0] = 4'b0000; d_blink[0] = 4'b0000;
      d_codes[1] = 16'h3210; d_en[1] = 4'b1111; d_dp[1] = 4'b0010; d_blink[1] = 4'b0000;
      d_codes[2] = 16'hEBBA; d_en[2] = 4'b1111; d_dp[2] = 4'b0000; d_blink[2] = 4'b0000;
      d_codes[3] = 16'h9876; d_en[3] = 4'b1111; d_dp[3] = 4'b1111; d_blink[3] = 4'b1000;
      d_codes[4] = 16'h5C5F; d_en[4] = 4'b0101; d_dp[4] = 4'b0000; d_blink[4] = 4'b0000;
      d_codes[5] = 16'h8888; d_en[5] = 4'b1111; d_dp[5] = 4'b0000; d_blink[5] = 4'b0000;

      // frame: shown set, load slots (cycle within frame, set)
      fr_show = '{0, 0, 1, 2, 3, 3, 3, 3, 3, 4};
      fr_k1   = '{-1, 5, 7, 4, -1, -1, -1, -1, 0, 2};
      fr_d1   = '{-1, 1, 2, 5, -1, -1, -1, -1, 4, 5};
      fr_k2   = '{-1, -1, -1, 15, -1, -1, -1, -1, -1, -1};
      fr_d2   = '{-1, -1, -1, 3, -1, -1, -1, -1, -1, -1};

      repeat (3) @(negedge clk);
      chk("reset_segments", 32'(segments), 32'h7f);
      chk("reset_dp", 32'(dp), 32'h1);
      chk("reset_anode", 32'(anode_active), 32'hf);
      chk("reset_frame_done", 32'(frame_done), 32'h0);

      rst = 1'b0;
      for (int f = 0; f < 10; f++) begin
         exp_q.push_back(exp_frame(fr_show[f], ((f / 2) % 2) == 1));
         for (int k = 0; k < 16; k++)
            cyc((k == fr_k1[f]) ? fr_d1[f] : ((k == fr_k2[f]) ? fr_d2[f] : -1));
      end

      // Frame showing "8888": queue a pending load, then reset while slot 2 is lit.
      for (int k = 0; k < 9; k++) cyc((k == 3) ? 1 : -1);
      chk("prereset_anode", 32'(anode_active), 32'hd);
      chk("prereset_segments", 32'(segments), 32'h00);
      rst = 1'b1;
      #1;
      chk("midreset_segments", 32'(segments), 32'h7f);
      chk("midreset_dp", 32'(dp), 32'h1);
      chk("midreset_anode", 32'(anode_active), 32'hf);
      chk("midreset_frame_done", 32'(frame_done), 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int f = 0; f < 2; f++) begin
         exp_q.push_back(exp_frame(0, 1'b0));
         for (int k = 0; k < 16; k++) cyc(-1);
      end
      @(negedge clk);
      chk("frames_outstanding", 32'(exp_q.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
- Parametrised, time-multiplexed N-digit seven-segment display driver for the Basys-3 calculator datapath.
- Scans one digit per refresh slot and decodes a 4-bit code per digit (digits, '-', 'r', 'E', blank).
- Adds per-digit enable, decimal points, blink mask, and frame-synchronous double-buffered loads so updates never tear mid-frame.
- Sits between the calculator result/format logic and the board's anode/cathode pins.

Parameters:
- NUM_DIGITS, 4, digits/anodes driven; legal range 2..8.
- REFRESH_DIV, 100000, clk cycles each digit stays lit; must be >= 2.
- BLINK_FRAMES, 64, full frames per blink half-period; must be >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  single-cycle strobe; captures digit_codes, dp_in, digit_en, blink_mask.
- digit_codes  input  4*NUM_DIGITS  code for anode k at bits [4k+3:4k].
- dp_in  input  NUM_DIGITS  decimal point request per anode, 1 = lit.
- digit_en  input  NUM_DIGITS  1 = digit shown, 0 = digit blank.
- blink_mask  input  NUM_DIGITS  1 = digit blinks.
- segments  output  [0:6]  active-low cathodes a..g, index 0 = a.
- dp  output  1  active-low decimal point.
- anode_active  output  NUM_DIGITS  active-low anodes, exactly one low or all high.
- frame_done  output  1  one-cycle pulse at end of each full scan.

Behaviour:
- Reset (asynchronous, rst high) forces: segments=7'b1111111, dp=1, anode_active all 1, frame_done=0, refresh counter=0, scan index=0, blink frame counter=0, blink phase=0, staging and active registers=0, pending=0.
- After reset the display is blank, because active digit_en=0.
- Refresh counter: counts 0..REFRESH_DIV-1. At REFRESH_DIV-1 it wraps to 0 and the scan index advances.
- Scan index: runs 0..NUM_DIGITS-1 and wraps to 0. Index i selects anode k = NUM_DIGITS-1-i, so the scan goes left to right starting at the MSB anode.
- Frame wrap: the cycle where the refresh counter is terminal and the index is NUM_DIGITS-1. frame_done is registered high the following cycle for exactly one cycle.
- Double buffer:
  - load=1 copies all four inputs into staging and sets pending.
  - At frame wrap with pending=1, active is loaded from staging and pending clears.
  - If load and frame wrap coincide, active is loaded directly from the live inputs, staging is also updated, and pending=0.
  - load while pending=1 overwrites staging (last load wins).
- Blink: the blink counter increments at each frame wrap. At BLINK_FRAMES-1 it wraps to 0 and blink phase toggles.
- Digit k is blanked when active digit_en[k]=0, or when active blink_mask[k]=1 and phase=1.
- Blanked digit: its anode stays high, segments=1111111, dp=1.
- Non-blank digit:
  - anode_active[k]=0 and every other anode is 1.
  - segments = decode(active code k).
  - dp = ~active dp_in[k].
- Decode table (segments[0..6]):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - 10 '-'=1111110, 11 'r'=0111001, 14 'E'=0110000
  - 12, 13, 15 = blank (1111111, anode still driven).
- Decode is fully specified; no latches are permitted.
- segments, dp and anode_active are registered and reflect the scan index of the previous cycle (1-cycle latency).
- Anode transitions are glitch-free: only one anode is low in any cycle.
- rst asserted mid-frame: all outputs return to reset values immediately. A pending load is discarded and scanning restarts at index 0 after deassertion.

Test Plan:
- All tests use NUM_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2.
- Reset/blank: release rst, no load, run 2 frames -> anode_active=4'b1111 and segments=1111111 throughout; frame_done pulses every 16 cycles.
- Load digits: load codes {3,2,1,0} (anode3..0), digit_en=1111, dp_in=0010 -> after the next frame wrap, anode 1110/1101/1011/0111 appear in order 0111,1011,1101,1110, each held 4 cycles with segments 0000110, 0010010, 1001111, 0000001; dp=0 only while anode_active=1101.
- Frame-synchronous load: pulse load mid-frame with codes {14,11,11,10} -> the current frame finishes with old digits and the next frame shows E,r,r,-. A load coincident with frame wrap -> new data visible in the very next slot.
- Blink: blink_mask=1000, all enabled -> anode 3 lit for 2 frames, dark for 2 frames, repeating; other anodes unaffected.
- Enable/blank codes: digit_en=0101 with codes 12 and 15 on the enabled digits -> anodes 1 and 3 never go low; anodes 0 and 2 go low with segments=1111111.
- Reset mid-operation: assert rst during slot 2 with load pending -> outputs go to reset values within the same cycle, and after release the display stays blank (pending discarded).
